cadena_uart_tx: RTL and testbench
=================================

// Module: cadena_uart_tx
// PURPOSE
//  Message sequencer + UART 8N1 transmitter; stage directly around the character lookup.
//  Drives character index car_cont upstream and reads back the character on dato.
//  dato[7:0] is the ASCII byte; dato[31:8] is ignored.
//  Serializes MSG_LEN characters LSB-first on tx per start request, then pulses done.
// PARAMETERS
//  CLKS_PER_BIT  10417  clk cycles per UART bit (100 MHz / 9600 baud); legal range >= 2
//  MSG_LEN       32     characters per message; indices 0..MSG_LEN-1; legal range 1..64
// PORTS
//  clk       in   1   system clock, rising edge
//  reset     in   1   asynchronous, active-high reset
//  start     in   1   request one message; sampled only in IDLE
//  car_cont  out  6   character index presented to the lookup stage
//  dato      in   32  character returned for car_cont (combinational path); bits [7:0] used
//  tx        out  1   UART serial line; idle high
//  busy      out  1   high from accepted start until done
//  done      out  1   one-cycle pulse after the last stop bit
// BEHAVIOUR
//  Clock/reset: one clock, clk; reset is asynchronous and active-high.
//  Reset values: tx=1, busy=0, done=0, car_cont=0, state=IDLE, bit/baud counters=0.
//  Reset mid-frame: tx returns to 1 immediately; message abandoned; no done pulse.
//  FSM states: IDLE -> LOAD -> START -> DATA -> STOP -> (LOAD | FINISH) ; FINISH -> IDLE.
//  IDLE:
//   - tx=1, busy=0.
//   - start=1 at edge N -> LOAD; busy=1 from N; car_cont=0.
//  LOAD:
//   - 1 cycle; dato[7:0] latched into shift register.
//   - car_cont is stable for the whole cycle, so the combinational lookup has settled.
//  START:
//   - tx=0 for exactly CLKS_PER_BIT cycles; first start bit begins at edge N+1.
//  DATA:
//   - 8 bits, LSB first; each bit held exactly CLKS_PER_BIT cycles.
//   - Shift register is unaffected by later changes on dato.
//  STOP:
//   - tx=1 for CLKS_PER_BIT cycles.
//   - At the end, if car_cont < MSG_LEN-1: car_cont+1 -> LOAD.
//   - Otherwise -> FINISH.
//  FINISH:
//   - done=1 for 1 cycle, busy=0, car_cont=0 -> IDLE.
//   - A start in this cycle is ignored; only start sampled in IDLE is accepted.
//  Timing:
//   - Per character: 1 + 10*CLKS_PER_BIT cycles.
//   - Accepted start to done: MSG_LEN*(1+10*CLKS_PER_BIT) + 1 cycles.
//  start while busy: ignored, not queued.
//  Counters:
//   - Baud counter is ceil(log2(CLKS_PER_BIT)) bits; counts 0..CLKS_PER_BIT-1 and wraps.
//   - Bit counter 0..7.
//   - car_cont is 6 bits; never exceeds MSG_LEN-1, so there is no wrap inside a message.
// STRUCTURE
//  cadena_pkg.vh (shared include):
//   - FSM state localparams.
//   - Default CLKS_PER_BIT and MSG_LEN.
//   - UART frame constants: 8 data bits, 1 stop bit.
//  Sub-module uart_tx_byte:
//   - Ports: clk, reset, load, byte_in[7:0], tx, frame_done.
//   - Owns START/DATA/STOP and the baud counter.
//  cadena_uart_tx:
//   - Owns IDLE/LOAD/FINISH, car_cont, busy, done.
// TESTING  (bench: CLKS_PER_BIT=4, MSG_LEN=3; model returns "H","o","l" for index 0,1,2)
//  1. Reset release, no start for 100 cycles:
//     - tx=1, busy=0, done=0, car_cont=0 throughout.
//  2. start pulse at edge N:
//     - tx=0 during cycles N+1..N+4.
//     - "H"=0x48 sent LSB first: 0,0,0,1,0,0,1,0 at 4 cycles each.
//     - Stop bit high 4 cycles.
//     - Then "o"=0x6F, then "l"=0x6C.
//     - done pulse at cycle N+124, lasting 1 cycle.
//  3. Model changes dato during the DATA state of char 0:
//     - Transmitted byte is still 0x48.
//     - car_cont steps 0->1->2 only at LOAD entry.
//  4. start held high for the whole message:
//     - Exactly one message, one done pulse.
//     - Next message begins only after IDLE is re-entered.
//  5. reset asserted mid-DATA of char 1, asynchronous to clk:
//     - tx=1, busy=0, car_cont=0 before the next clk edge.
//     - No done pulse is produced.
//  6. MSG_LEN=1 with a start pulse:
//     - Single frame 0x48.
//     - done at start+42 cycles; car_cont stays 0.

Source files
------------

// File: rtl/cadena_uart_tx_pkg.sv
// ============================================================================
// cadena_uart_tx_pkg
// Shared types and constants for the message sequencer and its byte serializer.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package cadena_uart_tx_pkg;

  localparam int c_def_clks_per_bit = 10417;
  localparam int c_def_msg_len      = 32;

  // 8N1 framing
  localparam int c_data_bits = 8;
  localparam int c_stop_bits = 1;

  typedef enum logic [1:0] {
    TOP_IDLE   = 2'd0,
    TOP_LOAD   = 2'd1,
    TOP_FRAME  = 2'd2,
    TOP_FINISH = 2'd3
  } top_state_e;

  typedef enum logic [1:0] {
    BYTE_IDLE  = 2'd0,
    BYTE_START = 2'd1,
    BYTE_DATA  = 2'd2,
    BYTE_STOP  = 2'd3
  } byte_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// uart_tx_byte
// Serializes one byte as start bit, 8 data bits LSB first and one stop bit.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte
  import cadena_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_def_clks_per_bit
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       frame_done
);

  localparam int                  c_baud_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [2:0]          c_last_bit  = 3'(c_data_bits - 1);

  byte_state_e         r_state, w_state_nxt;
  logic [c_baud_w-1:0] r_baud, w_baud_nxt;
  logic [2:0]          r_bit, w_bit_nxt;
  logic [7:0]          r_shift, w_shift_nxt;
  logic                r_tx, w_tx_nxt;
  logic                w_baud_end;

  assign w_baud_end = (r_baud == c_baud_last);
  assign tx         = r_tx;
  assign frame_done = (r_state == BYTE_STOP) && w_baud_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BYTE_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_baud_end ? '0 : r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    case (r_state)
      BYTE_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        if (load) begin
          w_state_nxt = BYTE_START;
          w_shift_nxt = byte_in;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b0;
        end
      end
      BYTE_START: begin
        if (w_baud_end) begin
          w_state_nxt = BYTE_DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      BYTE_DATA: begin
        // The line always shows r_shift[0]; shifting right exposes the next bit.
        if (w_baud_end) begin
          if (r_bit == c_last_bit) begin
            w_state_nxt = BYTE_STOP;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      BYTE_STOP: begin
        if (w_baud_end) begin
          w_state_nxt = BYTE_IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = BYTE_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cadena_uart_tx.sv
// ============================================================================
// cadena_uart_tx
// Walks character indices 0..MSG_LEN-1 through an external lookup and sends
// each returned byte over an 8N1 UART line, pulsing done after the last one.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module cadena_uart_tx
  import cadena_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_def_clks_per_bit,
  parameter int MSG_LEN      = c_def_msg_len
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [5:0]  car_cont,
  input  logic [31:0] dato,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] c_last_idx = 6'(MSG_LEN - 1);

  top_state_e r_state, w_state_nxt;
  logic [5:0] r_car_cont, w_car_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       w_load;
  logic       w_frame_done;
  logic       w_unused_dato;

  // Only the ASCII byte of the lookup word is transmitted.
  assign w_unused_dato = ^dato[31:8];

  assign car_cont = r_car_cont;
  assign busy     = r_busy;
  assign done     = r_done;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .byte_in   (dato[7:0]),
    .tx        (tx),
    .frame_done(w_frame_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= TOP_IDLE;
      r_car_cont <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_car_cont <= w_car_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_car_nxt   = r_car_cont;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      TOP_IDLE: begin
        if (start) begin
          w_state_nxt = TOP_LOAD;
          w_busy_nxt  = 1'b1;
          w_car_nxt   = '0;
        end
      end
      TOP_LOAD: begin
        // car_cont has been stable a full cycle, so dato has settled.
        w_load      = 1'b1;
        w_state_nxt = TOP_FRAME;
      end
      TOP_FRAME: begin
        if (w_frame_done) begin
          if (r_car_cont == c_last_idx) begin
            w_state_nxt = TOP_FINISH;
          end else begin
            w_car_nxt   = r_car_cont + 6'd1;
            w_state_nxt = TOP_LOAD;
          end
        end
      end
      TOP_FINISH: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_car_nxt   = '0;
        w_state_nxt = TOP_IDLE;
      end
      default: begin
        w_state_nxt = TOP_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cadena_uart_tx.sv
// ============================================================================
// tb_cadena_uart_tx
// Directed bench: 3-character message "Hol" at 4 clocks per bit, plus a
// single-character instance.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cadena_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic        corrupt;
  logic [5:0]  car0, car1;
  logic [31:0] dato0, dato1;
  logic        tx0, tx1, busy0, busy1, done0, done1;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] char_at(input logic [5:0] idx);
    case (idx)
      6'd0:    return 8'h48;
      6'd1:    return 8'h6F;
      6'd2:    return 8'h6C;
      default: return 8'h00;
    endcase
  endfunction

  always_comb dato0 = {24'hC0FFEE, (corrupt ? 8'hFF : char_at(car0))};
  always_comb dato1 = {24'hBADBAD, char_at(car1)};

  cadena_uart_tx #(.CLKS_PER_BIT(4), .MSG_LEN(3)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .car_cont(car0),
    .dato(dato0), .tx(tx0), .busy(busy0), .done(done0)
  );

  cadena_uart_tx #(.CLKS_PER_BIT(4), .MSG_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .car_cont(car1),
    .dato(dato1), .tx(tx1), .busy(busy1), .done(done1)
  );

  // Expected line level k cycles after the accepted start edge (41 cycles per char).
  function automatic logic exp_tx(input int k, input int n);
    int c, off;
    logic [7:0] ch;
    if (k < 1 || k > 41 * n) return 1'b1;
    c   = (k - 1) / 41;
    off = (k - 1) % 41;
    ch  = char_at(6'(c));
    if (off < 4)  return 1'b0;
    if (off < 36) return ch[(off - 4) / 4];
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int k, input int n);
    return (k <= 41 * n);
  endfunction

  function automatic logic exp_done(input int k, input int n);
    return (k == 41 * n + 1);
  endfunction

  function automatic logic [5:0] exp_car(input int k, input int n);
    int c;
    if (k > 41 * n) return 6'd0;
    c = k / 41;
    if (c > n - 1) c = n - 1;
    return 6'(c);
  endfunction

  task automatic test_reset();
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n_checks++;
      if ({tx0, busy0, done0, car0, tx1, busy1, done1, car1} !== {3'b100, 6'd0, 3'b100, 6'd0})
        $display("FAIL reset_idle cyc=%0d got tx/busy/done/car=%b%b%b/%0d and %b%b%b/%0d required 100/0",
                 k, tx0, busy0, done0, car0, tx1, busy1, done1, car1);
      else n_pass++;
    end
  endtask

  task automatic test_message(input bit inject, input string name);
    logic [8:0] obs, exp;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int k = 0; k <= 125; k++) begin
      if (k > 0) @(negedge clk);
      if (inject && k == 10) corrupt = 1'b1;
      if (inject && k == 30) corrupt = 1'b0;
      obs = {tx0, busy0, done0, car0};
      exp = {exp_tx(k, 3), exp_busy(k, 3), exp_done(k, 3), exp_car(k, 3)};
      n_checks++;
      if (obs !== exp)
        $display("FAIL %s k=%0d tx,busy,done,car=%b required %b", name, k, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    // k=63: bit 4 of 'o' (0), so the line is low when reset hits
    repeat (63) @(negedge clk);
    n_checks++;
    if ({tx0, busy0, car0} !== {2'b01, 6'd1})
      $display("FAIL pre_reset tx,busy,car=%b%b/%0d required 01/1", tx0, busy0, car0);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({tx0, busy0, done0, car0} !== {3'b100, 6'd0})
      $display("FAIL async_reset tx,busy,done,car=%b%b%b/%0d required 100/0", tx0, busy0, done0, car0);
    else n_pass++;
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 130; k++) begin
      @(negedge clk);
      n_checks++;
      if ({tx0, busy0, done0} !== 3'b100)
        $display("FAIL after_reset cyc=%0d tx,busy,done=%b%b%b required 100", k, tx0, busy0, done0);
      else n_pass++;
    end
  endtask

  task automatic test_start_held();
    logic [8:0] obs, exp;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 125; k++) begin
      if (k > 0) @(negedge clk);
      obs = {tx0, busy0, done0, car0};
      // idle is re-entered at k=124, so the held start re-launches at k=125
      exp = {exp_tx(k, 3), (k == 125) ? 1'b1 : exp_busy(k, 3), exp_done(k, 3), exp_car(k, 3)};
      n_checks++;
      if (obs !== exp)
        $display("FAIL start_held k=%0d tx,busy,done,car=%b required %b", k, obs, exp);
      else n_pass++;
    end
    start0 = 1'b0;
    reset  = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_char();
    logic [8:0] obs, exp;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int k = 0; k <= 44; k++) begin
      if (k > 0) @(negedge clk);
      obs = {tx1, busy1, done1, car1};
      exp = {exp_tx(k, 1), exp_busy(k, 1), exp_done(k, 1), exp_car(k, 1)};
      n_checks++;
      if (obs !== exp)
        $display("FAIL single_char k=%0d tx,busy,done,car=%b required %b", k, obs, exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_message(1'b0, "message_hol");
    test_message(1'b1, "dato_change");
    test_reset_mid_frame();
    test_start_held();
    test_single_char();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
